// File: rtl/dp_pkg.sv
// dp_pkg: shared selector codes and widths for the datapath scheduler slice
package dp_pkg;
    localparam logic SEL_ALT = 1'b0;
    localparam logic SEL_BAT = 1'b1;
    localparam int OPND_W = 8;
    localparam int RES_W = 16;
endpackage

// File: rtl/dp_tag_pipe.sv
// dp_tag_pipe: {valid, tag} shift register that tracks in-flight datapath operations
module dp_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic in_valid,
    input  logic in_tag,
    output logic out_valid,
    output logic out_tag,
    output logic busy
);
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] tag;
    // shift one stage per clock regardless of issue activity; clear drops everything in flight
    always_ff @(posedge clk) begin
        if (clr) begin
            vld <= '0;
            tag <= '0;
        end else begin
            vld[0] <= in_valid;
            tag[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end
    assign out_valid = vld[DEPTH-1];
    assign out_tag = tag[DEPTH-1];
    assign busy = |vld;
endmodule

// File: rtl/datapath_scheduler.sv
// datapath_scheduler: round-robin sharing of one pipelined datapath between altitude and battery clients
module datapath_scheduler
    import dp_pkg::*;
#(
    parameter int DP_LATENCY = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             alt_req,
    input  logic [OPND_W-1:0] alt_x1,
    input  logic [OPND_W-1:0] alt_x2,
    output logic             alt_ready,
    input  logic             bat_req,
    input  logic [OPND_W-1:0] bat_v,
    input  logic [OPND_W-1:0] bat_t,
    input  logic [OPND_W-1:0] bat_c,
    output logic             bat_ready,
    output logic [OPND_W-1:0] dp_x1,
    output logic [OPND_W-1:0] dp_x2,
    output logic [OPND_W-1:0] dp_v,
    output logic [OPND_W-1:0] dp_t,
    output logic [OPND_W-1:0] dp_c,
    output logic             dp_sel_eq,
    input  logic [RES_W-1:0]  dp_result_a,
    input  logic [RES_W-1:0]  dp_result_b,
    output logic             alt_valid,
    output logic [RES_W-1:0]  alt_result,
    output logic             bat_valid,
    output logic [RES_W-1:0]  bat_result,
    output logic [CNT_W-1:0]  alt_done_cnt,
    output logic [CNT_W-1:0]  bat_done_cnt,
    output logic             busy
);
    logic last_grant;
    logic pick_alt;
    logic alt_fire;
    logic bat_fire;
    logic out_valid;
    logic out_tag;
    logic cap_alt;
    logic cap_bat;
    // one-hot grant: contention and idle both resolve toward the client not served last
    always_comb begin
        pick_alt = bat_req ? (alt_req && last_grant == SEL_BAT) : (alt_req || last_grant == SEL_BAT);
        alt_ready = en && !rst && pick_alt;
        bat_ready = en && !rst && !pick_alt;
    end
    assign alt_fire = alt_req && alt_ready;
    assign bat_fire = bat_req && bat_ready;
    assign cap_alt = out_valid && out_tag == SEL_ALT;
    assign cap_bat = out_valid && out_tag == SEL_BAT;
    // operand registers load only for the granted client; the other side holds
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_x1 <= '0;
            dp_x2 <= '0;
            dp_v <= '0;
            dp_t <= '0;
            dp_c <= '0;
            dp_sel_eq <= SEL_ALT;
            last_grant <= SEL_BAT;
        end else if (alt_fire) begin
            dp_x1 <= alt_x1;
            dp_x2 <= alt_x2;
            dp_sel_eq <= SEL_ALT;
            last_grant <= SEL_ALT;
        end else if (bat_fire) begin
            dp_v <= bat_v;
            dp_t <= bat_t;
            dp_c <= bat_c;
            dp_sel_eq <= SEL_BAT;
            last_grant <= SEL_BAT;
        end
    end
    dp_tag_pipe #(.DEPTH(DP_LATENCY)) u_tag_pipe (
        .clk(clk),
        .clr(rst),
        .in_valid(alt_fire || bat_fire),
        .in_tag(alt_fire ? SEL_ALT : SEL_BAT),
        .out_valid(out_valid),
        .out_tag(out_tag),
        .busy(busy)
    );
    // capture the retiring result for its owner, pulse valid and bump the saturating counter
    always_ff @(posedge clk) begin
        if (rst) begin
            alt_valid <= 1'b0;
            bat_valid <= 1'b0;
            alt_result <= '0;
            bat_result <= '0;
            alt_done_cnt <= '0;
            bat_done_cnt <= '0;
        end else begin
            alt_valid <= cap_alt;
            bat_valid <= cap_bat;
            if (cap_alt) alt_result <= dp_result_a;
            if (cap_bat) bat_result <= dp_result_b;
            if (cap_alt && !(&alt_done_cnt)) alt_done_cnt <= alt_done_cnt + CNT_W'(1);
            if (cap_bat && !(&bat_done_cnt)) bat_done_cnt <= bat_done_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_datapath_scheduler.sv
// tb_datapath_scheduler: scoreboard bench with a behavioural two-stage datapath model
module tb_datapath_scheduler;
    localparam int L = 2;
    localparam int CW = 3;
    logic clk = 1'b0;
    logic rst, en, alt_req, bat_req;
    logic [7:0] alt_x1, alt_x2, bat_v, bat_t, bat_c;
    logic alt_ready, bat_ready;
    logic [7:0] dp_x1, dp_x2, dp_v, dp_t, dp_c;
    logic dp_sel_eq;
    logic [15:0] dp_result_a, dp_result_b;
    logic alt_valid, bat_valid;
    logic [15:0] alt_result, bat_result;
    logic [CW-1:0] alt_done_cnt, bat_done_cnt;
    logic busy;
    int cyc = 0;
    int passed = 0;
    int total = 0;
    int exp_alt = 0;
    int exp_bat = 0;
    typedef struct {
        logic sel;
        logic [15:0] res;
        int cyc;
    } exp_t;
    exp_t q[$];

    datapath_scheduler #(.DP_LATENCY(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .alt_req(alt_req), .alt_x1(alt_x1), .alt_x2(alt_x2), .alt_ready(alt_ready),
        .bat_req(bat_req), .bat_v(bat_v), .bat_t(bat_t), .bat_c(bat_c), .bat_ready(bat_ready),
        .dp_x1(dp_x1), .dp_x2(dp_x2), .dp_v(dp_v), .dp_t(dp_t), .dp_c(dp_c), .dp_sel_eq(dp_sel_eq),
        .dp_result_a(dp_result_a), .dp_result_b(dp_result_b),
        .alt_valid(alt_valid), .alt_result(alt_result),
        .bat_valid(bat_valid), .bat_result(bat_result),
        .alt_done_cnt(alt_done_cnt), .bat_done_cnt(bat_done_cnt), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] f_alt(logic signed [7:0] a, logic signed [7:0] b);
        return 16'(3 * a + 5 * b);
    endfunction
    function automatic logic [15:0] f_bat(logic signed [7:0] v, logic signed [7:0] t, logic signed [7:0] c);
        return 16'(v * t + c);
    endfunction
    function automatic int sat_inc(int v);
        return (v == (1 << CW) - 1) ? v : v + 1;
    endfunction

    // datapath model: operands registered at edge E give a result sampled at edge E+2
    always @(posedge clk) begin
        dp_result_a <= f_alt(dp_x1, dp_x2);
        dp_result_b <= f_bat(dp_v, dp_t, dp_c);
    end

    // scoreboard: retire pulses against the queue, then record handshakes due on the next edge
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_alt = 0;
            exp_bat = 0;
        end else begin
            if (alt_valid || bat_valid) begin
                total++;
                if (alt_valid && bat_valid) $display("FAIL dual_valid alt_valid=%0b bat_valid=%0b required one", alt_valid, bat_valid);
                else passed++;
                total++;
                if (q.size() == 0) $display("FAIL unexpected_pulse alt_valid=%0b bat_valid=%0b cyc=%0d required none", alt_valid, bat_valid, cyc);
                else begin
                    exp_t e;
                    logic [15:0] got;
                    passed++;
                    e = q.pop_front();
                    got = e.sel ? bat_result : alt_result;
                    total++;
                    if (bat_valid !== e.sel) $display("FAIL pulse_owner bat_valid=%0b required %0b", bat_valid, e.sel);
                    else passed++;
                    total++;
                    if (got !== e.res) $display("FAIL result sel=%0b got %0d required %0d", e.sel, $signed(got), $signed(e.res));
                    else passed++;
                    total++;
                    if (cyc !== e.cyc) $display("FAIL latency pulse cyc %0d required %0d", cyc, e.cyc);
                    else passed++;
                    if (e.sel) exp_bat = sat_inc(exp_bat);
                    else exp_alt = sat_inc(exp_alt);
                    total++;
                    if (alt_done_cnt !== CW'(exp_alt) || bat_done_cnt !== CW'(exp_bat))
                        $display("FAIL counters alt=%0d bat=%0d required %0d %0d", alt_done_cnt, bat_done_cnt, exp_alt, exp_bat);
                    else passed++;
                end
            end
            if (alt_req && alt_ready) q.push_back('{1'b0, f_alt(alt_x1, alt_x2), cyc + 1 + L});
            else if (bat_req && bat_ready) q.push_back('{1'b1, f_bat(bat_v, bat_t, bat_c), cyc + 1 + L});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        tick();
        total++;
        if (q.size() != 0) $display("FAIL drain pending=%0d required 0", q.size());
        else passed++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (alt_ready !== 1'b0 || bat_ready !== 1'b0) $display("FAIL reset_ready alt=%0b bat=%0b required 0 0", alt_ready, bat_ready);
        else passed++;
        total++;
        if ({dp_x1, dp_x2, dp_v, dp_t, dp_c, dp_sel_eq} !== 41'd0) $display("FAIL reset_operands got %h required 0", {dp_x1, dp_x2, dp_v, dp_t, dp_c, dp_sel_eq});
        else passed++;
        total++;
        if ({alt_valid, bat_valid, busy, alt_result, bat_result, alt_done_cnt, bat_done_cnt} !== 41'd0)
            $display("FAIL reset_outputs got %h required 0", {alt_valid, bat_valid, busy, alt_result, bat_result, alt_done_cnt, bat_done_cnt});
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (alt_ready !== 1'b1 || bat_ready !== 1'b0) $display("FAIL idle_tiebreak alt=%0b bat=%0b required 1 0", alt_ready, bat_ready);
        else passed++;
    endtask

    task automatic test_single_alt;
        alt_req = 1'b1;
        alt_x1 = 8'd3;
        alt_x2 = 8'd4;
        tick();
        alt_req = 1'b0;
        total++;
        if (dp_x1 !== 8'd3 || dp_x2 !== 8'd4 || dp_sel_eq !== 1'b0 || busy !== 1'b1)
            $display("FAIL alt_issue x1=%0d x2=%0d sel=%0b busy=%0b required 3 4 0 1", dp_x1, dp_x2, dp_sel_eq, busy);
        else passed++;
        drain();
        total++;
        if (alt_result !== 16'd29 || alt_done_cnt !== 3'd1 || bat_done_cnt !== 3'd0)
            $display("FAIL alt_single res=%0d cnt=%0d bcnt=%0d required 29 1 0", alt_result, alt_done_cnt, bat_done_cnt);
        else passed++;
    endtask

    task automatic test_single_bat;
        bat_req = 1'b1;
        bat_v = 8'd2;
        bat_t = 8'd5;
        bat_c = 8'd16;
        #1;
        total++;
        if (bat_ready !== 1'b1 || alt_ready !== 1'b0) $display("FAIL bat_only_ready alt=%0b bat=%0b required 0 1", alt_ready, bat_ready);
        else passed++;
        tick();
        bat_req = 1'b0;
        total++;
        if (dp_v !== 8'd2 || dp_t !== 8'd5 || dp_c !== 8'd16 || dp_sel_eq !== 1'b1 || dp_x1 !== 8'd3)
            $display("FAIL bat_issue v=%0d t=%0d c=%0d sel=%0b x1=%0d required 2 5 16 1 3", dp_v, dp_t, dp_c, dp_sel_eq, dp_x1);
        else passed++;
        drain();
        total++;
        if (bat_result !== 16'd26 || alt_result !== 16'd29) $display("FAIL bat_single res=%0d alt=%0d required 26 29", bat_result, alt_result);
        else passed++;
    endtask

    task automatic test_contention;
        alt_req = 1'b1;
        alt_x1 = 8'd10;
        alt_x2 = 8'd15;
        bat_req = 1'b1;
        bat_v = 8'd12;
        bat_t = 8'd8;
        bat_c = 8'd20;
        for (int i = 0; i < 12; i++) begin
            total++;
            if (alt_ready !== (i % 2 == 0) || bat_ready !== (i % 2 == 1))
                $display("FAIL alternate step=%0d alt=%0b bat=%0b required %0b %0b", i, alt_ready, bat_ready, i % 2 == 0, i % 2 == 1);
            else passed++;
            tick();
        end
        alt_req = 1'b0;
        bat_req = 1'b0;
        drain();
        total++;
        if (alt_result !== 16'd105 || bat_result !== 16'd116 || alt_done_cnt !== 3'd7 || bat_done_cnt !== 3'd7)
            $display("FAIL contention alt=%0d bat=%0d acnt=%0d bcnt=%0d required 105 116 7 7", alt_result, bat_result, alt_done_cnt, bat_done_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back;
        alt_req = 1'b1;
        alt_x1 = -8'sd5;
        alt_x2 = 8'd7;
        tick();
        alt_req = 1'b0;
        bat_req = 1'b1;
        bat_v = -8'sd3;
        bat_t = -8'sd2;
        bat_c = 8'd10;
        tick();
        bat_req = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL b2b_busy_issue busy=%0b required 1", busy);
        else passed++;
        tick();
        total++;
        if (busy !== 1'b1 || alt_valid !== 1'b1 || alt_result !== 16'd20)
            $display("FAIL b2b_alt busy=%0b valid=%0b res=%0d required 1 1 20", busy, alt_valid, $signed(alt_result));
        else passed++;
        tick();
        total++;
        if (busy !== 1'b0 || bat_valid !== 1'b1 || bat_result !== 16'd16)
            $display("FAIL b2b_bat busy=%0b valid=%0b res=%0d required 0 1 16", busy, bat_valid, $signed(bat_result));
        else passed++;
        drain();
        total++;
        if (alt_done_cnt !== 3'd7 || bat_done_cnt !== 3'd7) $display("FAIL saturate acnt=%0d bcnt=%0d required 7 7", alt_done_cnt, bat_done_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid;
        alt_req = 1'b1;
        alt_x1 = 8'd1;
        alt_x2 = 8'd2;
        tick();
        alt_req = 1'b0;
        bat_req = 1'b1;
        rst = 1'b1;
        #1;
        total++;
        if (alt_ready !== 1'b0 || bat_ready !== 1'b0) $display("FAIL rst_ready alt=%0b bat=%0b required 0 0", alt_ready, bat_ready);
        else passed++;
        tick();
        tick();
        bat_req = 1'b0;
        total++;
        if (busy !== 1'b0 || alt_valid !== 1'b0 || alt_done_cnt !== 3'd0 || bat_done_cnt !== 3'd0)
            $display("FAIL rst_mid busy=%0b valid=%0b acnt=%0d bcnt=%0d required 0 0 0 0", busy, alt_valid, alt_done_cnt, bat_done_cnt);
        else passed++;
        rst = 1'b0;
        repeat (4) tick();
        total++;
        if (alt_done_cnt !== 3'd0 || busy !== 1'b0) $display("FAIL rst_discard acnt=%0d busy=%0b required 0 0", alt_done_cnt, busy);
        else passed++;
    endtask

    task automatic test_en_low;
        bat_req = 1'b1;
        bat_v = 8'd1;
        bat_t = 8'd1;
        bat_c = 8'd1;
        tick();
        en = 1'b0;
        alt_req = 1'b1;
        alt_x1 = 8'd1;
        alt_x2 = 8'd1;
        bat_v = 8'd2;
        bat_t = 8'd2;
        bat_c = 8'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (alt_ready !== 1'b0 || bat_ready !== 1'b0) $display("FAIL en_low_ready step=%0d alt=%0b bat=%0b required 0 0", i, alt_ready, bat_ready);
            else passed++;
            tick();
        end
        total++;
        if (bat_done_cnt !== 3'd1 || bat_result !== 16'd2) $display("FAIL en_low_inflight bcnt=%0d res=%0d required 1 2", bat_done_cnt, bat_result);
        else passed++;
        en = 1'b1;
        #1;
        total++;
        if (alt_ready !== 1'b1 || bat_ready !== 1'b0) $display("FAIL en_rise_first alt=%0b bat=%0b required 1 0", alt_ready, bat_ready);
        else passed++;
        tick();
        total++;
        if (alt_ready !== 1'b0 || bat_ready !== 1'b1) $display("FAIL en_rise_second alt=%0b bat=%0b required 0 1", alt_ready, bat_ready);
        else passed++;
        tick();
        alt_req = 1'b0;
        bat_req = 1'b0;
        drain();
        total++;
        if (alt_result !== 16'd8 || bat_result !== 16'd6) $display("FAIL en_results alt=%0d bat=%0d required 8 6", alt_result, bat_result);
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        alt_req = 1'b0;
        bat_req = 1'b0;
        alt_x1 = '0;
        alt_x2 = '0;
        bat_v = '0;
        bat_t = '0;
        bat_c = '0;
        test_reset();
        test_single_alt();
        test_single_bat();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_en_low();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
